img_rx_ctrl: RTL and testbench

//  Frame-level sequencer for UART image download. Hunts for a 2-byte header, then

---
 rtl/img_rx_pkg.sv | 32 +++
 rtl/rx_timeout_timer.sv | 30 +++
 rtl/img_rx_ctrl.sv | 142 ++++++++++++++
 tb/tb_img_rx_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_rx_pkg.sv
// Shared constants for the UART image download sequencer:
// state codes, header bytes and error codes.
package img_rx_pkg;

  typedef enum logic [7:0] {
    ST_IDLE = 8'h01,
    ST_HDR1 = 8'h02,
    ST_RECV = 8'h04,
    ST_CHK  = 8'h08,
    ST_DONE = 8'h10,
    ST_ERR  = 8'h20
  } state_t;

  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;

  localparam int PIX_COUNT_DEF = 76800;
  localparam int TIMEOUT_DEF   = 5_000_000;

  typedef logic [1:0] err_t;

  localparam err_t ERR_NONE    = 2'b00;
  localparam err_t ERR_TIMEOUT = 2'b01;
  localparam err_t ERR_CSUM    = 2'b10;
  localparam err_t ERR_ABORT   = 2'b11;

  // States in which the inactivity timer is armed.
  function automatic logic is_waiting(state_t s);
    return s inside {ST_HDR1, ST_RECV, ST_CHK};
  endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Inactivity counter: cleared on events, counts while armed,
// saturates at TIMEOUT_CYC and flags expiry.
module rx_timeout_timer #(
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/img_rx_ctrl.sv
// Frame sequencer for UART image download: header hunt, pixel
// write-out to SRAM, XOR check against trailer, done/err report.
module img_rx_ctrl
  import img_rx_pkg::*;
#(
  parameter int          PIX_COUNT   = PIX_COUNT_DEF,
  parameter int          ADDR_W      = 17,
  parameter logic [7:0]  HDR0        = HDR0_DEF,
  parameter logic [7:0]  HDR1        = HDR1_DEF,
  parameter int          TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              i_clk_sys,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  input  logic [11:0]       i_pix,
  input  logic              i_pix_valid,
  input  logic [7:0]        i_check_code,
  input  logic              i_abort,
  output logic              o_image_receiving,
  output logic [7:0]        o_state,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [11:0]       o_sram_wdata,
  output logic              o_frame_done,
  output logic              o_frame_err,
  output logic [1:0]        o_err_code
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIX_COUNT - 1);

  state_t state, next;
  err_t fail_code;

  logic [ADDR_W-1:0] cnt;
  logic [7:0] acc;
  logic expired, evt, wr, last;
  logic tmr_clear, tmr_tick;

  // UART bytes belong to the pixel assembler while receiving.
  assign evt  = i_pix_valid || (i_rx_done && state != ST_RECV);
  assign wr   = state == ST_RECV && i_pix_valid && !i_abort;
  assign last = wr && cnt == LAST;

  always_comb begin
    next = state;
    fail_code = ERR_NONE;
    unique case (state)
      ST_IDLE: begin
        if (i_rx_done && i_rx_data == HDR0 && !i_abort)
          next = ST_HDR1;
      end
      ST_HDR1: begin
        if (i_rx_done) begin
          if (i_rx_data == HDR1)
            next = ST_RECV;
          else if (i_rx_data != HDR0)
            next = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (last)
          next = ST_CHK;
      end
      ST_CHK: begin
        if (i_rx_done) begin
          if (i_rx_data == acc) begin
            next = ST_DONE;
          end else begin
            next = ST_ERR;
            fail_code = ERR_CSUM;
          end
        end
      end
      default: next = ST_IDLE;
    endcase
    if (is_waiting(state)) begin
      if (i_abort) begin
        next = ST_ERR;
        fail_code = ERR_ABORT;
      end else if (expired && !evt) begin
        next = ST_ERR;
        fail_code = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= next;
  end

  assign tmr_tick  = is_waiting(state);
  assign tmr_clear = !tmr_tick || next != state || evt;

  rx_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (i_clk_sys),
    .rst    (i_rst),
    .clear  (tmr_clear),
    .tick   (tmr_tick),
    .expired(expired)
  );

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      cnt               <= '0;
      acc               <= '0;
      o_image_receiving <= 1'b0;
      o_sram_we         <= 1'b0;
      o_sram_addr       <= '0;
      o_sram_wdata      <= '0;
      o_frame_done      <= 1'b0;
      o_frame_err       <= 1'b0;
      o_err_code        <= ERR_NONE;
    end else begin
      o_sram_we <= wr;
      if (wr) begin
        o_sram_addr  <= cnt;
        o_sram_wdata <= i_pix;
        acc          <= acc ^ i_check_code;
        if (!last)
          cnt <= cnt + ADDR_W'(1);
      end
      if (next == ST_ERR || next == ST_IDLE) begin
        cnt <= '0;
        acc <= '0;
      end
      o_image_receiving <= next == ST_RECV;
      o_frame_done      <= next == ST_DONE;
      o_frame_err       <= next == ST_ERR;
      if (state == ST_IDLE && next == ST_HDR1)
        o_err_code <= ERR_NONE;
      else if (next == ST_ERR)
        o_err_code <= fail_code;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_img_rx_ctrl.sv
// Randomized bench for img_rx_ctrl with a frame-level reference
// model compared every cycle, plus directed literal checks.
module tb_img_rx_ctrl;

  localparam int P  = 4;
  localparam int AW = 17;
  localparam int T  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_done = 1'b0;
  logic [11:0] pix = '0;
  logic pix_valid = 1'b0;
  logic [7:0] code = '0;
  logic abort = 1'b0;

  logic recv, we, done, err;
  logic [7:0] st;
  logic [AW-1:0] addr;
  logic [11:0] wdata;
  logic [1:0] ecode;

  img_rx_ctrl #(
    .PIX_COUNT(P), .ADDR_W(AW), .HDR0(8'h55),
    .HDR1(8'hAA), .TIMEOUT_CYC(T)
  ) dut (
    .i_clk_sys(clk), .i_rst(rst),
    .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_pix(pix), .i_pix_valid(pix_valid),
    .i_check_code(code), .i_abort(abort),
    .o_image_receiving(recv), .o_state(st),
    .o_sram_we(we), .o_sram_addr(addr),
    .o_sram_wdata(wdata), .o_frame_done(done),
    .o_frame_err(err), .o_err_code(ecode)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 hdr1, 2 recv, 3 chk, 4 done, 5 err
  int ph = 0;
  int m_cnt = 0;
  int m_idle = 0;
  logic [7:0] m_acc = '0;
  logic [1:0] m_code = '0;
  logic e_recv = 0, e_we = 0, e_done = 0, e_err = 0;
  logic [AW-1:0] e_addr = '0;
  logic [11:0] e_wdata = '0;
  logic [7:0] codes [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

  task go_err(input logic [1:0] c);
    ph = 5;
    e_err = 1;
    m_code = c;
    m_cnt = 0;
    m_acc = '0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; m_cnt = 0; m_idle = 0; m_acc = '0; m_code = '0;
      e_recv = 0; e_we = 0; e_done = 0; e_err = 0;
      e_addr = '0; e_wdata = '0;
    end else begin
      e_we = 0; e_done = 0; e_err = 0;
      if (ph inside {1, 2, 3} && abort) begin
        go_err(2'b11);
      end else begin
        case (ph)
          0: if (rx_done && rx_data == 8'h55 && !abort) begin
               ph = 1; m_code = '0; m_idle = 0; m_cnt = 0; m_acc = '0;
             end
          1: if (rx_done) begin
               m_idle = 0;
               if (rx_data == 8'hAA) ph = 2;
               else if (rx_data != 8'h55) ph = 0;
             end else if (pix_valid) m_idle = 0;
             else if (m_idle == T) go_err(2'b01);
             else m_idle++;
          2: if (pix_valid) begin
               e_we = 1;
               e_addr = AW'(m_cnt);
               e_wdata = pix;
               m_acc ^= code;
               m_idle = 0;
               if (m_cnt == P - 1) ph = 3;
               else m_cnt++;
             end else if (m_idle == T) go_err(2'b01);
             else m_idle++;
          3: if (rx_done) begin
               if (rx_data == m_acc) begin ph = 4; e_done = 1; end
               else go_err(2'b10);
             end else if (pix_valid) m_idle = 0;
             else if (m_idle == T) go_err(2'b01);
             else m_idle++;
          default: ph = 0;
        endcase
      end
      e_recv = (ph == 2);
    end
  end

  always @(negedge clk) begin
    check("state", st, codes[ph]);
    check("recv", recv, e_recv);
    check("we", we, e_we);
    if (e_we) begin
      check("addr", addr, e_addr);
      check("wdata", wdata, e_wdata);
    end
    check("done", done, e_done);
    check("err", err, e_err);
    check("err_code", ecode, m_code);
  end

  int n_done = 0, n_err = 0;
  logic [AW-1:0] wa [$];
  logic [11:0] wd [$];
  logic [11:0] sent [$];

  always @(negedge clk) begin
    if (done) n_done++;
    if (err) n_err++;
    if (we) begin
      wa.push_back(addr);
      wd.push_back(wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1;
    tick();
    rx_done = 0;
    gap();
  endtask

  task automatic send_pix(input logic [11:0] p, input logic [7:0] c,
                          input bit junk);
    pix = p;
    code = c;
    pix_valid = 1;
    sent.push_back(p);
    tick();
    pix_valid = 0;
    if (junk && $urandom_range(0, 3) == 0) begin
      rx_data = 8'($urandom);
      rx_done = 1;
      tick();
      rx_done = 0;
    end
    gap();
  endtask

  task automatic send_frame(input logic [7:0] tweak);
    logic [7:0] x;
    logic [11:0] p;
    logic [7:0] c;
    x = '0;
    for (int i = 0; i < P; i++) begin
      p = 12'($urandom);
      c = 8'($urandom);
      x ^= c;
      send_pix(p, c, i < P - 1);
    end
    send_byte(x ^ tweak);
  endtask

  int d0, e0;
  logic [7:0] b;

  initial begin
    tick();
    tick();
    check("rst_state", st, 8'h01);
    check("rst_recv", recv, 0);
    check("rst_we", we, 0);
    check("rst_code", ecode, 0);
    rst = 0;
    tick();

    // good frame
    d0 = n_done; e0 = n_err;
    wa.delete(); wd.delete(); sent.delete();
    send_byte(8'h55);
    send_byte(8'hAA);
    send_frame(8'h00);
    repeat (3) tick();
    check("good_done_cnt", n_done - d0, 1);
    check("good_err_cnt", n_err - e0, 0);
    check("good_writes", wa.size(), 4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      check("good_addr", wa[i], i);
      check("good_data", wd[i], sent[i]);
    end

    // repeated first header byte
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'hAA);
    check("hdr_55_55_aa", st, 8'h04);
    check("hdr_recv", recv, 1);
    d0 = n_done;
    send_frame(8'h00);
    repeat (3) tick();
    check("hdr_done", n_done - d0, 1);

    // broken header
    send_byte(8'h55);
    send_byte(8'h12);
    check("bad_hdr_state", st, 8'h01);
    send_byte(8'hAA);
    check("bad_hdr_idle", st, 8'h01);
    check("bad_hdr_recv", recv, 0);

    // wrong trailer
    d0 = n_done; e0 = n_err;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_frame(8'h01);
    repeat (3) tick();
    check("csum_err", n_err - e0, 1);
    check("csum_nodone", n_done - d0, 0);
    check("csum_code", ecode, 2'b10);

    // stall after pixel 2
    e0 = n_err;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_pix(12'h123, 8'h11, 0);
    send_pix(12'h456, 8'h22, 0);
    repeat (T + 5) tick();
    check("tmo_err", n_err - e0, 1);
    check("tmo_code", ecode, 2'b01);
    check("tmo_recv", recv, 0);
    send_byte(8'h55);
    check("tmo_code_clr", ecode, 2'b00);
    send_byte(8'hAA);

    // abort while receiving
    e0 = n_err;
    send_pix(12'h789, 8'h33, 0);
    abort = 1;
    tick();
    abort = 0;
    repeat (2) tick();
    check("abort_err", n_err - e0, 1);
    check("abort_code", ecode, 2'b11);

    // async reset mid-frame
    d0 = n_done; e0 = n_err;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_pix(12'hABC, 8'h44, 0);
    #2;
    rst = 1;
    #1;
    check("arst_state", st, 8'h01);
    check("arst_recv", recv, 0);
    check("arst_we", we, 0);
    check("arst_addr", addr, 0);
    check("arst_wdata", wdata, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_code", ecode, 0);
    tick();
    rst = 0;
    repeat (2) tick();
    check("arst_nopulse", (n_done - d0) + (n_err - e0), 0);

    // randomized frames, checked cycle by cycle against the model
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: begin
          send_byte(8'h55); send_byte(8'hAA); send_frame(8'h00);
        end
        1: begin
          send_byte(8'h55); send_byte(8'hAA);
          send_frame(8'($urandom_range(1, 255)));
        end
        2: begin
          b = 8'($urandom);
          if (b == 8'h55 || b == 8'hAA) b = 8'h12;
          send_byte(8'h55); send_byte(b); send_byte(8'hAA);
        end
        3: begin
          send_pix(12'($urandom), 8'($urandom), 0);
        end
        default: begin
          send_byte(8'h55); send_byte(8'h55);
          send_byte(8'hAA); send_frame(8'h00);
        end
      endcase
      repeat (2) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
